fir_out_buffer: RTL and testbench

- Output stage directly downstream of Top_FIR. Captures each filtered 32-bit sample when Top_FIR flags data_out valid (start_toread), discards the first SKIP_N startup samples (filter pipeline fill), and buffers the rest in a FIFO.
- Delivers samples to the communication/DAC side over a valid/ready handshake.
- Drives Top_FIR's hold input as backpressure, with hysteresis.

---
 rtl/fir_out_buffer_if.sv | 30 +++
 rtl/fir_out_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_fir_out_buffer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fir_out_buffer_if.sv
// Handshake bundle between Top_FIR, the output buffer and the DAC-side consumer.
// The buffer takes the slave view; the surrounding environment drives the master view.
interface fir_out_buffer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] fir_data;
    logic              fir_valid;
    logic              hold;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output fir_data,
        output fir_valid,
        output out_ready,
        input  hold,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  fir_data,
        input  fir_valid,
        input  out_ready,
        output hold,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/fir_out_buffer.sv
// Output stage for Top_FIR: drops the pipeline-fill samples, buffers the rest in a
// first-word-fall-through FIFO, primes it before streaming, and drives hold as
// backpressure with hysteresis. Sticky overflow/underrun flags and a drop counter
// survive a flush and clear only on reset.
module fir_out_buffer #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int SKIP_N  = 7,
    parameter int PRIME_N = 4,
    parameter int HOLD_HI = 12,
    parameter int HOLD_LO = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    fir_out_buffer_if.slave   bus,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underrun,
    output logic [15:0]       drop_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam int SKIP_W = (SKIP_N < 2) ? 1 : $clog2(SKIP_N + 1);

    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  PRIME_C    = CNT_W'(PRIME_N);
    localparam logic [CNT_W-1:0]  HOLD_HI_C  = CNT_W'(HOLD_HI);
    localparam logic [CNT_W-1:0]  HOLD_LO_C  = CNT_W'(HOLD_LO);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ZERO   = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [SKIP_W-1:0] SKIP_ZERO  = {SKIP_W{1'b0}};
    localparam logic [SKIP_W-1:0] SKIP_ONE   = SKIP_W'(1);
    localparam logic [SKIP_W-1:0] SKIP_LAST  = SKIP_W'((SKIP_N > 0) ? (SKIP_N - 1) : 0);
    localparam logic [DATA_W-1:0] DATA_ZERO  = {DATA_W{1'b0}};
    localparam bit                SKIP_NONE  = (SKIP_N == 0);

    typedef enum logic [1:0] {
        ST_SKIP   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t             state_r;
    logic [DATA_W-1:0]  mem_r [DEPTH];
    logic [ADDR_W-1:0]  rd_ptr_r;
    logic [ADDR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [SKIP_W-1:0]  skip_cnt_r;
    logic               hold_r;
    logic               out_valid_r;
    logic [DATA_W-1:0]  out_data_r;
    logic               overflow_r;
    logic               underrun_r;
    logic [15:0]        drop_cnt_r;

    logic               pop_s;
    logic               active_s;
    logic               room_s;
    logic               push_s;
    logic               drop_s;
    logic               underrun_set_s;
    logic               hold_next_s;
    logic [CNT_W-1:0]   count_next_s;
    logic [ADDR_W-1:0]  rd_ptr_next_s;
    logic [ADDR_W-1:0]  wr_ptr_next_s;
    logic [DATA_W-1:0]  head_s;

    // Push/pop qualification, next occupancy, next pointers and the next FIFO head.
    always_comb begin
        pop_s         = out_valid_r & bus.out_ready & ~flush;
        active_s      = (state_r != ST_SKIP);
        room_s        = (count_r != DEPTH_C) | pop_s;
        push_s        = bus.fir_valid & active_s & room_s & ~flush;
        drop_s        = bus.fir_valid & active_s & ~room_s & ~flush;
        count_next_s  = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        rd_ptr_next_s = pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        wr_ptr_next_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        underrun_set_s = (state_r == ST_STREAM) & (count_next_s == CNT_ZERO) & ~flush;
        // The head slot may be the one being written this very cycle (empty or last-word case).
        if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_s = bus.fir_data;
        end else begin
            head_s = mem_r[rd_ptr_next_s];
        end
        if (count_next_s >= HOLD_HI_C) begin
            hold_next_s = 1'b1;
        end else if (count_next_s <= HOLD_LO_C) begin
            hold_next_s = 1'b0;
        end else begin
            hold_next_s = hold_r;
        end
    end

    // Sample storage; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            mem_r[wr_ptr_r] <= bus.fir_data;
        end
    end

    // Skip/prime/stream control with registered head data, valid, hold and occupancy.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_r     <= ST_SKIP;
            skip_cnt_r  <= SKIP_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            wr_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            hold_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= DATA_ZERO;
        end else begin
            rd_ptr_r <= rd_ptr_next_s;
            wr_ptr_r <= wr_ptr_next_s;
            count_r  <= count_next_s;
            hold_r   <= hold_next_s;
            case (state_r)
                ST_SKIP: begin
                    out_valid_r <= 1'b0;
                    out_data_r  <= DATA_ZERO;
                    if (SKIP_NONE) begin
                        state_r <= ST_PRIME;
                    end else if (bus.fir_valid) begin
                        skip_cnt_r <= skip_cnt_r + SKIP_ONE;
                        if (skip_cnt_r == SKIP_LAST) begin
                            state_r <= ST_PRIME;
                        end else begin
                            state_r <= ST_SKIP;
                        end
                    end else begin
                        state_r <= ST_SKIP;
                    end
                end
                ST_PRIME: begin
                    if ((count_next_s >= PRIME_C) && (count_next_s != CNT_ZERO)) begin
                        state_r     <= ST_STREAM;
                        out_valid_r <= 1'b1;
                        out_data_r  <= head_s;
                    end else begin
                        state_r     <= ST_PRIME;
                        out_valid_r <= 1'b0;
                        out_data_r  <= DATA_ZERO;
                    end
                end
                ST_STREAM: begin
                    if (count_next_s == CNT_ZERO) begin
                        state_r     <= ST_PRIME;
                        out_valid_r <= 1'b0;
                        out_data_r  <= DATA_ZERO;
                    end else begin
                        state_r     <= ST_STREAM;
                        out_valid_r <= 1'b1;
                        out_data_r  <= head_s;
                    end
                end
                default: begin
                    state_r     <= ST_SKIP;
                    out_valid_r <= 1'b0;
                    out_data_r  <= DATA_ZERO;
                end
            endcase
        end
    end

    // Sticky error flags and saturating drop counter; a flush leaves them untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r <= 1'b0;
            underrun_r <= 1'b0;
            drop_cnt_r <= 16'h0000;
        end else begin
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_cnt_r != 16'hFFFF) begin
                    drop_cnt_r <= drop_cnt_r + 16'h0001;
                end else begin
                    drop_cnt_r <= drop_cnt_r;
                end
            end else begin
                overflow_r <= overflow_r;
                drop_cnt_r <= drop_cnt_r;
            end
            if (underrun_set_s) begin
                underrun_r <= 1'b1;
            end else begin
                underrun_r <= underrun_r;
            end
        end
    end

    assign bus.hold      = hold_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign count         = count_r;
    assign overflow      = overflow_r;
    assign underrun      = underrun_r;
    assign drop_cnt      = drop_cnt_r;
endmodule

// File: tb/tb_fir_out_buffer.sv
// Bench for fir_out_buffer: directed scenarios followed by random traffic, with a
// queue-based reference model feeding an expected-sample scoreboard and a monitor
// that checks outputs on the falling edge.
module tb_fir_out_buffer;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 4;
    localparam int SKIP_N  = 7;
    localparam int PRIME_N = 4;
    localparam int HOLD_HI = 12;
    localparam int HOLD_LO = 8;
    localparam int DEPTH   = 16;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underrun;
    logic [15:0]       drop_cnt;

    fir_out_buffer_if #(.DATA_W(DATA_W)) bus();

    fir_out_buffer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SKIP_N(SKIP_N),
        .PRIME_N(PRIME_N), .HOLD_HI(HOLD_HI), .HOLD_LO(HOLD_LO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .bus(bus),
        .count(count),
        .overflow(overflow),
        .underrun(underrun),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Scoreboard: samples the buffer is expected to deliver, oldest first.
    logic [31:0] exp_q[$];

    // Reference model state, expressed in terms of the behavioural rules.
    int m_count   = 0;
    int m_skipped = 0;
    int m_drop    = 0;
    bit m_stream  = 1'b0;
    bit m_hold    = 1'b0;
    bit m_ovf     = 1'b0;
    bit m_und     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit v;
        bit rdy;
        bit pop;
        bit acc;
        v   = bus.fir_valid;
        rdy = bus.out_ready;
        if (reset) begin
            m_count = 0; m_skipped = 0; m_stream = 0; m_hold = 0;
            m_ovf = 0; m_und = 0; m_drop = 0;
            exp_q.delete();
        end else if (flush) begin
            m_count = 0; m_skipped = 0; m_stream = 0; m_hold = 0;
            exp_q.delete();
        end else begin
            pop = m_stream && (m_count > 0) && rdy;
            acc = 1'b0;
            if (m_skipped < SKIP_N) begin
                if (v) m_skipped++;
            end else begin
                if (v) begin
                    if (m_count < DEPTH || pop) begin
                        acc = 1'b1;
                        exp_q.push_back(bus.fir_data);
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drop < 65535) m_drop++;
                    end
                end
                m_count = m_count + int'(acc) - int'(pop);
                if (!m_stream && m_count >= PRIME_N) begin
                    m_stream = 1'b1;
                end else if (m_stream && m_count == 0) begin
                    m_stream = 1'b0;
                    m_und    = 1'b1;
                end
            end
            if (m_count >= HOLD_HI) m_hold = 1'b1;
            else if (m_count <= HOLD_LO) m_hold = 1'b0;
        end
    endtask

    // Reference model advances on every rising edge with the inputs presented there.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: compares status every falling edge and consumes the scoreboard on handshakes.
    initial begin
        forever begin
            @(negedge clk);
            chk("count", 32'(count), 32'(m_count));
            chk("hold", 32'(bus.hold), 32'(m_hold));
            chk("out_valid", 32'(bus.out_valid), 32'(m_stream && (m_count > 0)));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underrun", 32'(underrun), 32'(m_und));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("data_unexpected", bus.out_data, 32'hFFFF_FFFF ^ bus.out_data);
                end else begin
                    chk("data", bus.out_data, exp_q[0]);
                    if (bus.out_ready && !flush && !reset) begin
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("data_idle", bus.out_data, 32'h0);
            end
        end
    end

    task automatic cyc(input bit v, input logic [31:0] d, input bit rdy, input bit f, input bit r);
        bus.fir_valid = v;
        bus.fir_data  = d;
        bus.out_ready = rdy;
        flush         = f;
        reset         = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.fir_valid = 1'b0;
        bus.fir_data  = 32'h0;
        bus.out_ready = 1'b0;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);

        // Startup skip then prime; out_valid rises with the fourth kept sample.
        for (int i = 1; i <= 7; i++) cyc(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
        for (int i = 100; i <= 102; i++) cyc(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
        chk("prime_valid_low", 32'(bus.out_valid), 32'h0);
        cyc(1'b1, 32'd103, 1'b1, 1'b0, 1'b0);
        chk("prime_valid_high", 32'(bus.out_valid), 32'h1);
        chk("prime_head", bus.out_data, 32'd100);

        // Stall the consumer and overfill.
        for (int i = 0; i < 16; i++) cyc(1'b1, 32'(200 + i), 1'b0, 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'd16);
        chk("full_hold", 32'(bus.hold), 32'h1);
        chk("full_overflow", 32'(overflow), 32'h1);
        chk("full_drops", 32'(drop_cnt), 32'd4);

        // Drain to empty: hold releases, underrun is flagged, re-prime needed.
        for (int i = 0; i < 20; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("drain_count", 32'(count), 32'h0);
        chk("drain_underrun", 32'(underrun), 32'h1);
        chk("drain_hold", 32'(bus.hold), 32'h0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'(300 + i), 1'b1, 1'b0, 1'b0);
        chk("reprime_low", 32'(bus.out_valid), 32'h0);
        cyc(1'b1, 32'd303, 1'b1, 1'b0, 1'b0);
        chk("reprime_high", 32'(bus.out_valid), 32'h1);

        // Fill, then push and pop together while full across pointer wrap.
        for (int i = 0; i < 12; i++) cyc(1'b1, 32'(400 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'(450 + i), 1'b1, 1'b0, 1'b0);
        chk("wrap_count", 32'(count), 32'd16);
        chk("wrap_drops", 32'(drop_cnt), 32'd4);

        // Flush with five buffered samples and a valid in the flush cycle.
        for (int i = 0; i < 11; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("preflush_count", 32'(count), 32'd5);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
        chk("flush_count", 32'(count), 32'h0);
        chk("flush_valid", 32'(bus.out_valid), 32'h0);
        chk("flush_hold", 32'(bus.hold), 32'h0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 32'(500 + i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'(600 + i), 1'b1, 1'b0, 1'b0);
        chk("flush_drops_kept", 32'(drop_cnt), 32'd4);
        chk("flush_overflow_kept", 32'(overflow), 32'h1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 9) < 7), $urandom, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 99) == 0), ($urandom_range(0, 499) == 0));
        end

        // Reset in the middle of streaming with hold asserted.
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 32'(700 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) cyc(1'b1, 32'(800 + i), 1'b0, 1'b0, 1'b0);
        chk("prereset_hold", 32'(bus.hold), 32'h1);
        chk("prereset_valid", 32'(bus.out_valid), 32'h1);
        cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
        chk("reset_hold", 32'(bus.hold), 32'h0);
        chk("reset_valid", 32'(bus.out_valid), 32'h0);
        chk("reset_data", bus.out_data, 32'h0);
        chk("reset_count", 32'(count), 32'h0);
        chk("reset_overflow", 32'(overflow), 32'h0);
        chk("reset_underrun", 32'(underrun), 32'h0);
        chk("reset_drops", 32'(drop_cnt), 32'h0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 32'(900 + i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'(950 + i), 1'b1, 1'b0, 1'b0);
        chk("reskip_head", bus.out_data, 32'd950);
        for (int i = 0; i < 8; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("final_empty", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
